// File: rtl/register_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional feature macro: REGISTER_FILE_MP_BYPASS_EN (see register_file_mp.sv).
package register_file_mp_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Index of the highest set bit of a port-match vector, or -1 when none is set.
    // The highest-numbered port therefore wins any collision.
    function automatic int onehot_last_match(input logic [31:0] match);
        int win;
        win = -1;
        for (int k = 0; k < 32; k++) begin
            if (match[k]) begin
                win = k;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/register_file_mp_chk.sv
// Property checker for register_file_mp: zero register, pending[0], bulk-clear length.
module register_file_mp_chk #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3,
    parameter int NUM_RD     = 2
) (
    input logic                         clk,
    input logic                         rst_n,
    input logic [NUM_RD*DEPTH-1:0]      rd_addr_i,
    input logic [NUM_RD*DATA_WIDTH-1:0] rd_data_i,
    input logic [NUM_RD-1:0]            rd_ready_i,
    input logic                         pending0_i,
    input logic                         busy_i
);

    localparam logic [DEPTH:0] CNT_ONE  = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [DEPTH:0] CNT_FULL = {1'b1, {DEPTH{1'b0}}};

    logic [DEPTH:0] busy_cnt_q;

    // Counts consecutive busy cycles so the sweep length can be checked when busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
        end else if (busy_i) begin
            busy_cnt_q <= busy_cnt_q + CNT_ONE;
        end else begin
            busy_cnt_q <= '0;
        end
    end

    a_busy_len: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(busy_i) |-> (busy_cnt_q == CNT_FULL));

    a_pending0: assert property (@(posedge clk) disable iff (!rst_n) !pending0_i);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        a_rd_zero: assert property (@(posedge clk) disable iff (!rst_n)
            (rd_addr_i[i*DEPTH +: DEPTH] == DEPTH'(0)) |->
            ((rd_data_i[i*DATA_WIDTH +: DATA_WIDTH] == DATA_WIDTH'(0)) && rd_ready_i[i]));
    end

endmodule

// File: rtl/register_file_mp_clr_fsm.sv
// Bulk-clear sequencer: walks idx from 1 to 2**DEPTH-1, then spends one DONE cycle.
module register_file_mp_clr_fsm
    import register_file_mp_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             clr_en_o,
    output logic [DEPTH-1:0] clr_idx_o,
    output logic             busy_o
);

    localparam logic [DEPTH-1:0] IDX_FIRST = DEPTH'(1);
    localparam logic [DEPTH-1:0] IDX_LAST  = {DEPTH{1'b1}};

    clr_state_e       state_q, state_d;
    logic [DEPTH-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             clr_en_q, clr_en_d;

    // Next-state logic; the sweep ends by comparing against the last index, never by wrapping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLR_IDLE: begin
                if (start_i) begin
                    state_d = CLR_SWEEP;
                    idx_d   = IDX_FIRST;
                end else begin
                    state_d = CLR_IDLE;
                end
            end
            CLR_SWEEP: begin
                if (idx_q == IDX_LAST) begin
                    state_d = CLR_DONE;
                end else begin
                    idx_d = idx_q + DEPTH'(1);
                end
            end
            CLR_DONE: begin
                state_d = CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
        busy_d   = (state_d != CLR_IDLE);
        clr_en_d = (state_d == CLR_SWEEP);
    end

    // State, index and decoded output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLR_IDLE;
            idx_q    <= IDX_FIRST;
            busy_q   <= 1'b0;
            clr_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            clr_en_q <= clr_en_d;
        end
    end

    assign clr_en_o  = clr_en_q;
    assign clr_idx_o = idx_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with pending scoreboard bits and a sequenced bulk clear.
// Define REGISTER_FILE_MP_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*DEPTH-1:0]      in_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] out_rd_data,
    output logic [NUM_RD-1:0]            out_rd_ready,
    input  logic [NUM_WR-1:0]            in_we,
    input  logic [NUM_WR*DEPTH-1:0]      in_wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] in_wr_data,
    input  logic                         in_rsv_valid,
    input  logic [DEPTH-1:0]             in_rsv_addr,
    output logic                         out_rsv_ready,
    input  logic                         in_clr_start,
    output logic                         out_clr_busy
);

    localparam int                    NUM_REGS  = 2 ** DEPTH;
    localparam logic [DEPTH-1:0]      ADDR_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    logic                  clr_en_s;
    logic [DEPTH-1:0]      clr_idx_s;
    logic                  busy_s;
    logic                  rsv_ready_s;
    logic [DEPTH-1:0]      wr_addr_s [NUM_WR];
    logic [DATA_WIDTH-1:0] wr_data_s [NUM_WR];
    logic [NUM_WR-1:0]     wr_act_s;

    register_file_mp_clr_fsm #(
        .DEPTH (DEPTH)
    ) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (in_clr_start),
        .clr_en_o  (clr_en_s),
        .clr_idx_o (clr_idx_s),
        .busy_o    (busy_s)
    );

    // Unpack write ports; a port is live only outside a sweep and when not aimed at register 0.
    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wr_addr_s[j] = in_wr_addr[j*DEPTH +: DEPTH];
            wr_data_s[j] = in_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            wr_act_s[j]  = in_we[j] && !busy_s && (wr_addr_s[j] != ADDR_ZERO);
        end
    end

    assign rsv_ready_s = in_rsv_valid && (in_rsv_addr != ADDR_ZERO)
                         && !pending_q[in_rsv_addr] && !busy_s;

    // Storage next state: writes clear pending, a same-cycle reservation then sets it again.
    always_comb begin
        logic [NUM_WR-1:0] match;
        int                win;
        mem_d     = mem_q;
        pending_d = pending_q;
        match     = '0;
        win       = -1;
        for (int a = 1; a < NUM_REGS; a++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                match[j] = wr_act_s[j] && (wr_addr_s[j] == DEPTH'(a));
            end
            win = onehot_last_match(32'(match));
            for (int j = 0; j < NUM_WR; j++) begin
                if (j == win) begin
                    mem_d[a]     = wr_data_s[j];
                    pending_d[a] = 1'b0;
                end else begin
                    mem_d[a] = mem_d[a];
                end
            end
        end
        if (clr_en_s) begin
            mem_d[clr_idx_s]     = DATA_ZERO;
            pending_d[clr_idx_s] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (rsv_ready_s) begin
            pending_d[in_rsv_addr] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        mem_d[0]     = DATA_ZERO;
        pending_d[0] = 1'b0;
    end

    // Storage and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                mem_q[a] <= DATA_ZERO;
            end
            pending_q <= '0;
        end else begin
            mem_q     <= mem_d;
            pending_q <= pending_d;
        end
    end

    // Combinational read ports, optionally forwarding the winning same-cycle write.
    always_comb begin
        logic [DEPTH-1:0]  ra;
`ifdef REGISTER_FILE_MP_BYPASS_EN
        logic [NUM_WR-1:0] hit;
        int                win;
        hit = '0;
        win = -1;
`endif
        ra           = ADDR_ZERO;
        out_rd_data  = '0;
        out_rd_ready = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = in_rd_addr[i*DEPTH +: DEPTH];
            if (ra == ADDR_ZERO) begin
                out_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_ZERO;
                out_rd_ready[i]                         = 1'b1;
            end else begin
                out_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
                out_rd_ready[i]                         = !pending_q[ra];
            end
`ifdef REGISTER_FILE_MP_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                hit[j] = wr_act_s[j] && (wr_addr_s[j] == ra);
            end
            win = onehot_last_match(32'(hit));
            for (int j = 0; j < NUM_WR; j++) begin
                if (j == win) begin
                    out_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_s[j];
                    out_rd_ready[i]                         = 1'b1;
                end else begin
                    out_rd_ready[i] = out_rd_ready[i];
                end
            end
`endif
        end
    end

    assign out_rsv_ready = rsv_ready_s;
    assign out_clr_busy  = busy_s;

    register_file_mp_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .NUM_RD     (NUM_RD)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (in_rd_addr),
        .rd_data_i  (out_rd_data),
        .rd_ready_i (out_rd_ready),
        .pending0_i (pending_q[0]),
        .busy_i     (busy_s)
    );

endmodule
